reg_file_param: RTL and testbench



---
 rtl/reg_file_param.sv | 98 +++++++++
 tb/tb_reg_file_param.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two combinational read ports,
// optional hard-wired zero register, optional write-to-read bypass and a
// multi-cycle bulk-clear sweep that wipes the file without a global reset.
module reg_file_param #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Wenable,
  input  logic [ADDR_W-1:0] WrtAddress,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [ADDR_W-1:0] RdAddress1,
  input  logic [ADDR_W-1:0] RdAddress2,
  output logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataB,
  input  logic              Clear,
  output logic              Busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LastIdx = '1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic write_ok;
  logic byp_a, byp_b;

  // Writes to r0 are discarded when it is hard-wired to zero.
  assign write_ok = Wenable && !(ZERO_R0 && (WrtAddress == '0));

  // Next-state: normal writes and sweep start in IDLE, one entry zeroed per cycle in CLEAR.
  always_comb begin
    mem_d   = mem_q;
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == StIdle) begin
      // A write on the Clear edge still lands; the sweep erases it afterwards.
      if (write_ok) begin
        mem_d[WrtAddress] = DataIn;
      end
      if (Clear) begin
        state_d = StClear;
        idx_d   = '0;
      end
    end else begin
      mem_d[idx_q] = '0;
      idx_d        = idx_q + 1'b1;
      if (idx_q == LastIdx) begin
        state_d = StIdle;
      end
    end
  end

  // State registers with synchronous, dominant reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      mem_q   <= '{default: '0};
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Forwarding only applies to writes that would actually commit this edge.
  assign byp_a = BYPASS && (state_q == StIdle) && write_ok && (RdAddress1 == WrtAddress);
  assign byp_b = BYPASS && (state_q == StIdle) && write_ok && (RdAddress2 == WrtAddress);

  // Read port A: zero register overrides bypass, bypass overrides storage.
  always_comb begin
    DataA = byp_a ? DataIn : mem_q[RdAddress1];
    if (ZERO_R0 && (RdAddress1 == '0)) begin
      DataA = '0;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    DataB = byp_b ? DataIn : mem_q[RdAddress2];
    if (ZERO_R0 && (RdAddress2 == '0)) begin
      DataB = '0;
    end
  end

  assign Busy = (state_q == StClear);

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param. A second instance with
// bypass disabled shares all inputs so both bypass settings are observed.
module tb_reg_file_param;

  logic        clk;
  logic        Reset;
  logic        Wenable;
  logic [4:0]  WrtAddress;
  logic [31:0] DataIn;
  logic [4:0]  RdAddress1;
  logic [4:0]  RdAddress2;
  logic [31:0] DataA, DataB, DataA0, DataB0;
  logic        Clear;
  logic        Busy, Busy0;

  int checks = 0;
  int errors = 0;

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .Reset(Reset), .Wenable(Wenable), .WrtAddress(WrtAddress), .DataIn(DataIn),
    .RdAddress1(RdAddress1), .RdAddress2(RdAddress2), .DataA(DataA), .DataB(DataB),
    .Clear(Clear), .Busy(Busy)
  );

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .Reset(Reset), .Wenable(Wenable), .WrtAddress(WrtAddress), .DataIn(DataIn),
    .RdAddress1(RdAddress1), .RdAddress2(RdAddress2), .DataA(DataA0), .DataB(DataB0),
    .Clear(Clear), .Busy(Busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int unsigned offset);
    for (int i = 1; i < 32; i++) begin
      Wenable    = 1'b1;
      WrtAddress = 5'(i);
      DataIn     = 32'(i) + offset;
      tick();
    end
    Wenable = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      RdAddress1 = 5'(i);
      RdAddress2 = 5'(31 - i);
      #1;
      checks++;
      if (DataA !== 32'h0 || DataB !== 32'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d: A=%h B=%h required 0", i, DataA, DataB);
      end
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b required 0", Busy);
    end
  endtask

  task automatic test_write_read();
    Wenable = 1'b1; WrtAddress = 5'd5; DataIn = 32'hDEADBEEF;
    tick();
    WrtAddress = 5'd31; DataIn = 32'h12345678;
    tick();
    Wenable = 1'b0; RdAddress1 = 5'd5; RdAddress2 = 5'd31;
    #1;
    checks++;
    if (DataA !== 32'hDEADBEEF || DataB !== 32'h12345678) begin
      errors++;
      $display("FAIL write_read: A=%h B=%h required deadbeef 12345678", DataA, DataB);
    end
    checks++;
    if (DataA0 !== 32'hDEADBEEF || DataB0 !== 32'h12345678) begin
      errors++;
      $display("FAIL write_read_nobyp: A=%h B=%h required deadbeef 12345678", DataA0, DataB0);
    end
  endtask

  task automatic test_zero_r0();
    Wenable = 1'b1; WrtAddress = 5'd0; DataIn = 32'hAAAA5555;
    RdAddress1 = 5'd0; RdAddress2 = 5'd0;
    #1;
    checks++;
    if (DataA !== 32'h0 || DataB !== 32'h0) begin
      errors++;
      $display("FAIL r0_write_cycle: A=%h B=%h required 0", DataA, DataB);
    end
    tick();
    Wenable = 1'b0;
    #1;
    checks++;
    if (DataA !== 32'h0 || DataB !== 32'h0 || DataA0 !== 32'h0) begin
      errors++;
      $display("FAIL r0_after: A=%h B=%h A0=%h required 0", DataA, DataB, DataA0);
    end
  endtask

  task automatic test_bypass();
    Wenable = 1'b1; WrtAddress = 5'd7; DataIn = 32'h1;
    tick();
    DataIn = 32'hCAFEF00D; RdAddress1 = 5'd7; RdAddress2 = 5'd5;
    #1;
    checks++;
    if (DataA !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bypass_a: got %h required cafef00d", DataA);
    end
    checks++;
    if (DataA0 !== 32'h1) begin
      errors++;
      $display("FAIL nobypass_a: got %h required 00000001", DataA0);
    end
    checks++;
    if (DataB !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass_b_other_addr: got %h required deadbeef", DataB);
    end
    RdAddress2 = 5'd7;
    #1;
    checks++;
    if (DataB !== 32'hCAFEF00D || DataB0 !== 32'h1) begin
      errors++;
      $display("FAIL bypass_b: B=%h B0=%h required cafef00d 00000001", DataB, DataB0);
    end
    tick();
    Wenable = 1'b0;
    #1;
    checks++;
    if (DataA0 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL write_commit: got %h required cafef00d", DataA0);
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    busy_cnt = 0;
    fill(0);
    Clear = 1'b1;
    tick();  // edge t0
    Clear = 1'b0;
    RdAddress1 = 5'd3; RdAddress2 = 5'd20;
    // Write during sweep: must be dropped and must not bypass.
    Wenable = 1'b1; WrtAddress = 5'd10; DataIn = 32'h55;
    for (int e = 0; e < 40; e++) begin
      #1;
      if (Busy === 1'b1) busy_cnt++;
      if (e == 2) begin
        checks++;
        if (DataB !== 32'd20) begin
          errors++;
          $display("FAIL clear_unswept_r20: got %h required 00000014", DataB);
        end
        RdAddress2 = 5'd10;
      end
      if (e == 3) begin
        checks++;
        if (DataA !== 32'd3) begin
          errors++;
          $display("FAIL clear_r3_t0p3: got %h required 00000003", DataA);
        end
      end
      if (e == 5) begin
        checks++;
        if (DataA !== 32'd0) begin
          errors++;
          $display("FAIL clear_r3_t0p5: got %h required 0", DataA);
        end
        checks++;
        if (DataB !== 32'd10) begin
          errors++;
          $display("FAIL clear_no_bypass: got %h required 0000000a", DataB);
        end
      end
      if (e == 15) Wenable = 1'b0;
      tick();
    end
    checks++;
    if (busy_cnt != 32) begin
      errors++;
      $display("FAIL clear_busy_len: got %0d cycles required 32", busy_cnt);
    end
    RdAddress1 = 5'd10; RdAddress2 = 5'd31;
    #1;
    checks++;
    if (DataA !== 32'h0 || DataB !== 32'h0) begin
      errors++;
      $display("FAIL clear_after: r10=%h r31=%h required 0", DataA, DataB);
    end
  endtask

  task automatic test_back_to_back();
    bit done;
    Clear = 1'b1;
    tick();  // t0
    for (int e = 0; e < 34; e++) begin
      #1;
      if (e == 31) begin
        checks++;
        if (Busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy_last: got %b required 1", Busy);
        end
      end
      if (e == 32) begin
        checks++;
        if (Busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle_gap: got %b required 0", Busy);
        end
      end
      if (e == 33) begin
        checks++;
        if (Busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_restart: got %b required 1", Busy);
        end
      end
      tick();
    end
    Clear = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (Busy === 1'b0) done = 1'b1;
      else tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL b2b_timeout: Busy=%b required 0 within 64 cycles", Busy);
    end
  endtask

  task automatic test_reset_abort();
    fill(100);
    Clear = 1'b1;
    tick();  // t0
    Clear = 1'b0;
    for (int e = 0; e < 9; e++) tick();
    Reset = 1'b1;
    tick();  // t0+10
    Reset = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b required 0", Busy);
    end
    for (int i = 0; i < 32; i++) begin
      RdAddress1 = 5'(i);
      RdAddress2 = 5'(31 - i);
      #1;
      checks++;
      if (DataA !== 32'h0 || DataB !== 32'h0) begin
        errors++;
        $display("FAIL abort_read addr=%0d: A=%h B=%h required 0", i, DataA, DataB);
      end
    end
    Wenable = 1'b1; WrtAddress = 5'd2; DataIn = 32'h2222;
    tick();
    Wenable = 1'b0; RdAddress1 = 5'd2;
    #1;
    checks++;
    if (DataA !== 32'h2222 || DataA0 !== 32'h2222) begin
      errors++;
      $display("FAIL abort_write: A=%h A0=%h required 00002222", DataA, DataA0);
    end
  endtask

  initial begin
    Reset = 1'b0; Wenable = 1'b0; WrtAddress = '0; DataIn = '0;
    RdAddress1 = '0; RdAddress2 = '0; Clear = 1'b0;
    test_reset();
    test_write_read();
    test_zero_r0();
    test_bypass();
    test_clear();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
